axi_reg_master: RTL and testbench
=================================

# axi_reg_master

AXI4-Lite slave that turns processor register accesses into transactions on the internal register bus (`reg_req`/`reg_wr`/`reg_addr`/`reg_wdata`/`reg_ack`/`reg_rdata`). It is the initiator for the peripheral register block, which handles the UART, keyboard and mouse registers. It sits between the Zynq PS general-purpose AXI port and that block. It serialises reads and writes, handles one transaction at a time, and returns SLVERR if the register bus does not answer within a bounded time.

## Interface
- `ADDR_BITS`, 8: width of `reg_addr`; taken from the low bits of the AXI address.
- `TIMEOUT`, 255: cycles to wait for `reg_ack` after `reg_req` before aborting; valid range 1–65535.

- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `axi_awvalid` in 1, `axi_awready` out 1, `axi_awaddr` in 32: write address channel.
- `axi_wvalid` in 1, `axi_wready` out 1, `axi_wdata` in 32, `axi_wstrb` in 4: write data channel; `axi_wstrb` is ignored and every write is full-word.
- `axi_bvalid` out 1, `axi_bready` in 1, `axi_bresp` out 2: write response channel.
- `axi_arvalid` in 1, `axi_arready` out 1, `axi_araddr` in 32: read address channel.
- `axi_rvalid` out 1, `axi_rready` in 1, `axi_rdata` out 32, `axi_rresp` out 2: read data channel.
- `reg_req` out 1: single-cycle request strobe.
- `reg_wr` out 1: 1 = write, 0 = read; valid while a request is outstanding.
- `reg_addr` out ADDR_BITS: byte address, passed through unmodified.
- `reg_wdata` out 32: write data.
- `reg_ack` in 1: completion strobe from the responder.
- `reg_rdata` in 32: read data, valid in the cycle `reg_ack` is high.

## Operation
- **States:**
  - IDLE: collect address/data, arbitrate.
  - REQ: `reg_req` is high for exactly this one cycle.
  - WAIT: wait for `reg_ack` or timeout.
  - BRESP: `axi_bvalid` held until `axi_bready`.
  - RRESP: `axi_rvalid` held until `axi_rready`.
- **Write capture (IDLE only):**
  - AW and W are captured independently into holding registers, each with a captured flag.
  - `axi_awready` = IDLE && !aw_captured; `axi_wready` = IDLE && !w_captured.
  - AW and W may arrive in either order or in the same cycle.
- **Read capture:** `axi_arready` = IDLE && !ar_captured && !write_selected.
- **Arbitration:** from IDLE, go to REQ when either a complete write (AW and W both captured) or a captured read is pending.
  - If both are pending, round-robin: the kind not served last wins.
  - After reset, write wins the first tie.
- **Request fields:**
  - `reg_addr`, `reg_wr` and `reg_wdata` are driven from the holding registers.
  - They are stable from the REQ cycle through the cycle `reg_ack` is seen or the timeout fires.
  - `reg_req` must never be high for more than one cycle per transaction; the responder acts once per cycle of `reg_req`.
- **WAIT:**
  - `reg_ack` = 1 → latch `reg_rdata` into `axi_rdata` (reads only), resp = 2'b00 (OKAY), go to BRESP or RRESP.
  - Counter reaches TIMEOUT → resp = 2'b10 (SLVERR), `axi_rdata` = 32'hDEADBEEF for reads, go to BRESP or RRESP.
- **Completion:**
  - Leaving BRESP or RRESP clears the corresponding captured flag(s) and returns to IDLE.
  - Any `reg_ack` outside WAIT (late ack after a timeout, spurious ack) is ignored.
- **Reset values:**
  - All AXI ready/valid outputs 0; `axi_bresp` and `axi_rresp` 0; `axi_rdata` 0.
  - `reg_req` 0, `reg_wr` 0, `reg_addr` 0, `reg_wdata` 0.
  - All captured flags cleared; state IDLE; round-robin favours write.
- **Reset mid-transaction:** everything returns to reset values immediately; the pending AXI transaction is dropped, not completed.

## Timing
- **Capture:** a handshake (valid && ready) at edge N sets the captured flag at N; the ready signal is low from N+1.
- **Write with AW and W in the same edge N:**
  - `reg_req` = 1 in cycle N+1.
  - Earliest `reg_ack` in cycle N+2.
  - `axi_bvalid` = 1 from cycle N+3.
  - Next `axi_awready` high in the cycle after the B handshake.
- **Read:** same timing as a write, with `axi_rvalid` from N+3 and `axi_rdata` equal to `reg_rdata` sampled in the ack cycle.
- **Ack in the REQ cycle:** ignored; WAIT begins sampling in the cycle after REQ.
- **Timeout counter:** cleared in REQ, increments each WAIT cycle without ack; SLVERR is taken in the cycle the count equals TIMEOUT.
- **Ack and timeout in the same cycle:** ack wins (OKAY).
- **Throughput:** at most one outstanding register transaction; no pipelining.

## Test plan
- **Single write:** AW+W at addr 0x14, data 0x00200010 in one cycle → one-cycle `reg_req`, `reg_wr`=1, `reg_addr`=0x14, `reg_wdata`=0x00200010; ack after 1 cycle → `axi_bresp`=00, `axi_bvalid` held through 3 cycles of `axi_bready`=0.
- **Split write:** W three cycles before AW → exactly one `reg_req`, issued the cycle after AW is accepted; `axi_wready` low while waiting.
- **Read:** AR addr 0x10, responder returns 0x80000041 → `axi_rdata`=0x80000041, `axi_rresp`=00.
- **Contention:** write and read pending together after reset → write served first, then the read; repeat the tie → read served first.
- **Timeout:** TIMEOUT=4, no ack → SLVERR, `axi_rdata`=0xDEADBEEF on a read; an ack arriving 2 cycles later is ignored and no second `reg_req` is issued.
- **Reset mid-transaction:** `rst` in WAIT → all outputs at reset values next cycle; the following transaction completes normally.

Source files
------------

// File: rtl/axi_reg_master.sv
// AXI4-Lite slave bridging processor register accesses onto the single-outstanding
// internal register bus (reg_req/reg_ack), with SLVERR on responder timeout.
module axi_reg_master #(
  parameter int ADDR_BITS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [31:0]          axi_awaddr,

  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  input  logic [31:0]          axi_wdata,
  input  logic [3:0]           axi_wstrb,

  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  output logic [1:0]           axi_bresp,

  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  input  logic [31:0]          axi_araddr,

  output logic                 axi_rvalid,
  input  logic                 axi_rready,
  output logic [31:0]          axi_rdata,
  output logic [1:0]           axi_rresp,

  output logic                 reg_req,
  output logic                 reg_wr,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [31:0]          reg_wdata,
  input  logic                 reg_ack,
  input  logic [31:0]          reg_rdata
);

  localparam logic [15:0] TMO         = 16'(TIMEOUT);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ERR_RDATA   = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_BRESP,
    S_RRESP
  } state_t;

  state_t                 r_state;
  logic                   r_live;
  logic                   r_aw_cap;
  logic                   r_w_cap;
  logic                   r_ar_cap;
  logic                   r_last_wr;
  logic                   r_cur_wr;
  logic [15:0]            r_cnt;

  logic [ADDR_BITS-1:0]   r_awaddr;
  logic [31:0]            r_wdata;
  logic [ADDR_BITS-1:0]   r_araddr;

  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic                   r_rvalid;
  logic [1:0]             r_rresp;
  logic [31:0]            r_rdata;

  logic                   r_reg_req;
  logic                   r_reg_wr;
  logic [ADDR_BITS-1:0]   r_reg_addr;
  logic [31:0]            r_reg_wdata;

  logic                   w_idle;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_ar_hs;
  logic                   w_wr_pend;
  logic                   w_rd_pend;
  logic                   w_pick_wr;
  logic                   w_timeout;
  logic [ADDR_BITS-1:0]   w_awaddr_now;
  logic [31:0]            w_wdata_now;
  logic [ADDR_BITS-1:0]   w_araddr_now;
  logic                   w_unused;

  // r_live keeps every ready low in the cycle straight after reset.
  assign w_idle      = r_live && (r_state == S_IDLE);
  assign axi_awready = w_idle && !r_aw_cap;
  assign axi_wready  = w_idle && !r_w_cap;
  assign axi_arready = w_idle && !r_ar_cap && !(r_aw_cap && r_w_cap);

  assign w_aw_hs = axi_awvalid && axi_awready;
  assign w_w_hs  = axi_wvalid  && axi_wready;
  assign w_ar_hs = axi_arvalid && axi_arready;

  // Arbitration sees handshakes of this very edge so a same-edge AW+W issues at once.
  assign w_wr_pend = (r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs);
  assign w_rd_pend = r_ar_cap || w_ar_hs;
  assign w_pick_wr = w_wr_pend && (!w_rd_pend || !r_last_wr);

  assign w_awaddr_now = r_aw_cap ? r_awaddr : axi_awaddr[ADDR_BITS-1:0];
  assign w_wdata_now  = r_w_cap  ? r_wdata  : axi_wdata;
  assign w_araddr_now = r_ar_cap ? r_araddr : axi_araddr[ADDR_BITS-1:0];

  assign w_timeout = (r_cnt == TMO);

  // Upper address bits and byte strobes carry no meaning on this bus.
  assign w_unused = &{1'b0, axi_awaddr, axi_araddr, axi_wstrb};

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= axi_awaddr[ADDR_BITS-1:0];
    if (w_w_hs)  r_wdata  <= axi_wdata;
    if (w_ar_hs) r_araddr <= axi_araddr[ADDR_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_aw_cap    <= 1'b0;
      r_w_cap     <= 1'b0;
      r_ar_cap    <= 1'b0;
      r_last_wr   <= 1'b0;
      r_cur_wr    <= 1'b0;
      r_cnt       <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rresp     <= RESP_OKAY;
      r_rdata     <= '0;
      r_reg_req   <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      r_live    <= 1'b1;
      r_reg_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) r_aw_cap <= 1'b1;
          if (w_w_hs)  r_w_cap  <= 1'b1;
          if (w_ar_hs) r_ar_cap <= 1'b1;
          if (w_wr_pend || w_rd_pend) begin
            r_state    <= S_REQ;
            r_reg_req  <= 1'b1;
            r_cur_wr   <= w_pick_wr;
            r_last_wr  <= w_pick_wr;
            r_reg_wr   <= w_pick_wr;
            r_reg_addr <= w_pick_wr ? w_awaddr_now : w_araddr_now;
            if (w_pick_wr) r_reg_wdata <= w_wdata_now;
          end
        end
        S_REQ: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (reg_ack) begin
            if (r_cur_wr) begin
              r_bvalid <= 1'b1;
              r_bresp  <= RESP_OKAY;
              r_state  <= S_BRESP;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= RESP_OKAY;
              r_rdata  <= reg_rdata;
              r_state  <= S_RRESP;
            end
          end else if (w_timeout) begin
            if (r_cur_wr) begin
              r_bvalid <= 1'b1;
              r_bresp  <= RESP_SLVERR;
              r_state  <= S_BRESP;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= RESP_SLVERR;
              r_rdata  <= ERR_RDATA;
              r_state  <= S_RRESP;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_BRESP: begin
          if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RRESP: begin
          if (axi_rready) begin
            r_rvalid <= 1'b0;
            r_ar_cap <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign axi_bvalid = r_bvalid;
  assign axi_bresp  = r_bresp;
  assign axi_rvalid = r_rvalid;
  assign axi_rresp  = r_rresp;
  assign axi_rdata  = r_rdata;

  assign reg_req   = r_reg_req;
  assign reg_wr    = r_reg_wr;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;

endmodule

// File: tb/tb_axi_reg_master.sv
// Directed bench for axi_reg_master with a short TIMEOUT so the abort path is quick to reach.
module tb_axi_reg_master;

  localparam int ADDR_BITS = 8;
  localparam int TIMEOUT   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 axi_awvalid = 1'b0;
  logic                 axi_awready;
  logic [31:0]          axi_awaddr = '0;
  logic                 axi_wvalid = 1'b0;
  logic                 axi_wready;
  logic [31:0]          axi_wdata = '0;
  logic [3:0]           axi_wstrb = 4'hF;
  logic                 axi_bvalid;
  logic                 axi_bready = 1'b0;
  logic [1:0]           axi_bresp;
  logic                 axi_arvalid = 1'b0;
  logic                 axi_arready;
  logic [31:0]          axi_araddr = '0;
  logic                 axi_rvalid;
  logic                 axi_rready = 1'b0;
  logic [31:0]          axi_rdata;
  logic [1:0]           axi_rresp;
  logic                 reg_req;
  logic                 reg_wr;
  logic [ADDR_BITS-1:0] reg_addr;
  logic [31:0]          reg_wdata;
  logic                 reg_ack = 1'b0;
  logic [31:0]          reg_rdata = '0;

  int checks  = 0;
  int errors  = 0;
  int req_cnt = 0;
  int req_base;

  axi_reg_master #(.ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // One count per clock cycle in which the strobe is high.
  always @(posedge clk) if (reg_req === 1'b1) req_cnt++;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_awready", 32'(axi_awready), 32'd0);
    chk("rst_wready",  32'(axi_wready),  32'd0);
    chk("rst_arready", 32'(axi_arready), 32'd0);
    chk("rst_bvalid",  32'(axi_bvalid),  32'd0);
    chk("rst_rvalid",  32'(axi_rvalid),  32'd0);
    chk("rst_rdata",   axi_rdata,        32'd0);
    chk("rst_req",     32'(reg_req),     32'd0);
    chk("rst_addr",    32'(reg_addr),    32'd0);
    chk("rst_wdata",   reg_wdata,        32'd0);
    rst = 1'b0;
    tick();
    chk("idle_awready", 32'(axi_awready), 32'd1);
    chk("idle_arready", 32'(axi_arready), 32'd1);

    // Single write, AW and W on the same edge
    req_base = req_cnt;
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_0014;
    axi_wvalid  = 1'b1; axi_wdata  = 32'h0020_0010;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("w1_req",     32'(reg_req),     32'd1);
    chk("w1_wr",      32'(reg_wr),      32'd1);
    chk("w1_addr",    32'(reg_addr),    32'h14);
    chk("w1_wdata",   reg_wdata,        32'h0020_0010);
    chk("w1_awready", 32'(axi_awready), 32'd0);
    tick();
    chk("w1_req_low", 32'(reg_req), 32'd0);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    chk("w1_bvalid", 32'(axi_bvalid), 32'd1);
    chk("w1_bresp",  32'(axi_bresp),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w1_bhold", 32'(axi_bvalid), 32'd1);
    end
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    chk("w1_bdone",     32'(axi_bvalid),  32'd0);
    chk("w1_awready_b", 32'(axi_awready), 32'd1);
    chk("w1_reqcnt",    32'(req_cnt - req_base), 32'd1);

    // Split write: W three edges before AW
    req_base = req_cnt;
    axi_wvalid = 1'b1; axi_wdata = 32'h0000_00A5;
    tick();
    axi_wvalid = 1'b0;
    chk("w2_wready0", 32'(axi_wready), 32'd0);
    tick();
    chk("w2_wready1", 32'(axi_wready), 32'd0);
    chk("w2_noreq",   32'(reg_req),    32'd0);
    tick();
    chk("w2_wready2", 32'(axi_wready), 32'd0);
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_0008;
    tick();
    axi_awvalid = 1'b0;
    chk("w2_req",   32'(reg_req),  32'd1);
    chk("w2_addr",  32'(reg_addr), 32'h08);
    chk("w2_wdata", reg_wdata,     32'h0000_00A5);
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    chk("w2_bvalid", 32'(axi_bvalid), 32'd1);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    chk("w2_reqcnt", 32'(req_cnt - req_base), 32'd1);

    // Read
    req_base = req_cnt;
    axi_arvalid = 1'b1; axi_araddr = 32'h0000_0010;
    tick();
    axi_arvalid = 1'b0;
    chk("r1_req",  32'(reg_req),  32'd1);
    chk("r1_wr",   32'(reg_wr),   32'd0);
    chk("r1_addr", 32'(reg_addr), 32'h10);
    tick();
    reg_ack = 1'b1; reg_rdata = 32'h8000_0041;
    tick();
    reg_ack = 1'b0; reg_rdata = 32'h0;
    chk("r1_rvalid", 32'(axi_rvalid), 32'd1);
    chk("r1_rdata",  axi_rdata,       32'h8000_0041);
    chk("r1_rresp",  32'(axi_rresp),  32'd0);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    chk("r1_rdone",  32'(axi_rvalid), 32'd0);
    chk("r1_reqcnt", 32'(req_cnt - req_base), 32'd1);

    // Reset while waiting for the responder
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_0020;
    axi_wvalid  = 1'b1; axi_wdata  = 32'h0000_0011;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mr_req",     32'(reg_req),     32'd0);
    chk("mr_wr",      32'(reg_wr),      32'd0);
    chk("mr_addr",    32'(reg_addr),    32'd0);
    chk("mr_wdata",   reg_wdata,        32'd0);
    chk("mr_awready", 32'(axi_awready), 32'd0);
    chk("mr_bvalid",  32'(axi_bvalid),  32'd0);
    rst = 1'b0;
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    chk("mr_dropped", 32'(axi_bvalid),  32'd0);
    chk("mr_awready", 32'(axi_awready), 32'd1);

    // Contention after reset: write wins, then a fresh tie goes to the read
    req_base = req_cnt;
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_0030;
    axi_wvalid  = 1'b1; axi_wdata  = 32'h0000_0033;
    axi_arvalid = 1'b1; axi_araddr = 32'h0000_0034;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    chk("c1_wr",   32'(reg_wr),   32'd1);
    chk("c1_addr", 32'(reg_addr), 32'h30);
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    chk("c1_bvalid", 32'(axi_bvalid), 32'd1);
    axi_bready  = 1'b1;
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_0038;
    axi_wvalid  = 1'b1; axi_wdata  = 32'h0000_0077;
    tick();
    axi_bready = 1'b0;
    chk("c2_awready", 32'(axi_awready), 32'd1);
    chk("c2_arready", 32'(axi_arready), 32'd0);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("c2_req",  32'(reg_req),  32'd1);
    chk("c2_wr",   32'(reg_wr),   32'd0);
    chk("c2_addr", 32'(reg_addr), 32'h34);
    tick();
    reg_ack = 1'b1; reg_rdata = 32'h5A5A_0001;
    tick();
    reg_ack = 1'b0; reg_rdata = 32'h0;
    chk("c2_rdata", axi_rdata, 32'h5A5A_0001);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    chk("c3_arready", 32'(axi_arready), 32'd0);
    tick();
    chk("c3_wr",    32'(reg_wr),    32'd1);
    chk("c3_addr",  32'(reg_addr),  32'h38);
    chk("c3_wdata", reg_wdata,      32'h0000_0077);
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    chk("c3_bresp", 32'(axi_bresp), 32'd0);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    chk("c_reqcnt", 32'(req_cnt - req_base), 32'd3);

    // Read timeout, then a late ack that must be ignored
    req_base = req_cnt;
    axi_arvalid = 1'b1; axi_araddr = 32'h0000_0044;
    tick();
    axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_pre_rvalid", 32'(axi_rvalid), 32'd0);
    tick();
    chk("t1_rvalid", 32'(axi_rvalid), 32'd1);
    chk("t1_rresp",  32'(axi_rresp),  32'd2);
    chk("t1_rdata",  axi_rdata,       32'hDEAD_BEEF);
    tick();
    reg_ack = 1'b1; reg_rdata = 32'h1234_5678;
    tick();
    reg_ack = 1'b0; reg_rdata = 32'h0;
    chk("t1_late_rdata", axi_rdata,       32'hDEAD_BEEF);
    chk("t1_late_rresp", 32'(axi_rresp),  32'd2);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    tick(); tick();
    chk("t1_reqcnt", 32'(req_cnt - req_base), 32'd1);

    // Ack during REQ is ignored, so this write times out with SLVERR
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_0050;
    axi_wvalid  = 1'b1; axi_wdata  = 32'h0000_0099;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_pre_bvalid", 32'(axi_bvalid), 32'd0);
    tick();
    chk("t2_bvalid", 32'(axi_bvalid), 32'd1);
    chk("t2_bresp",  32'(axi_bresp),  32'd2);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;

    // Ack in the same cycle the count reaches TIMEOUT: ack wins
    axi_arvalid = 1'b1; axi_araddr = 32'h0000_0060;
    tick();
    axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reg_ack = 1'b1; reg_rdata = 32'hCAFE_0005;
    tick();
    reg_ack = 1'b0; reg_rdata = 32'h0;
    chk("t3_rvalid", 32'(axi_rvalid), 32'd1);
    chk("t3_rresp",  32'(axi_rresp),  32'd0);
    chk("t3_rdata",  axi_rdata,       32'hCAFE_0005);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    chk("t3_rdone", 32'(axi_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
